// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants and scheduler state type for the BNN run path
// Purpose: default image/output sizes, X-memory bank-select codes, scheduler FSM states.
// Ports: none (package).
package bnn_pkg;

  localparam int X1_LEN  = 784;
  localparam int OUT_LEN = 10;

  // X memory bank-select codes; the host image always lands in BANK_X1.
  localparam int BANK_X1 = 0;
  localparam int BANK_X2 = 1;
  localparam int BANK_X3 = 2;
  localparam int BANK_X4 = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_WAIT = 3'd1,
    S_LD_WR   = 3'd2,
    S_LD_FIN  = 3'd3,
    S_ARM     = 3'd4,
    S_RUN     = 3'd5,
    S_DONE    = 3'd6
  } sched_state_e;

endpackage

// File: rtl/bnn_first_one.sv
// rtl/bnn_first_one.sv - lowest-set-bit encoder with none flag
// Purpose: cls = index of lowest 1 in bits (0 if none); none = no bit set. Purely combinational.
// Ports: bits (in, N), cls (out, W), none (out, 1).
module bnn_first_one #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] cls,
  output logic         none
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    cls  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) begin
        cls  = W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bnn_run_scheduler.sv
// rtl/bnn_run_scheduler.sv - sequencer for one binary-NN inference run
// Purpose: loads a host image into X bank 0, arms and runs the engine, captures OUT_LEN output
//   bits, reports result with argmax class; owns the shared X-memory write port.
// Ports: clk, rst_n (sync active-low); start, busy; pix_vld/pix_data/pix_rdy host pixel stream;
//   res_vld/res_bits/res_class/res_none/res_tmo/res_ack result; eng_en/eng_finish engine control;
//   eng_x_* engine X-port request; eng_out_vld/eng_out_bit engine outputs; mem_x_* muxed X port.
module bnn_run_scheduler #(
  parameter int X_ADDR_LEN = 10,
  parameter int X_SEL_LEN  = 2,
  parameter int X1_LEN     = bnn_pkg::X1_LEN,
  parameter int OUT_LEN    = bnn_pkg::OUT_LEN,
  parameter int CLS_W      = 4,
  parameter int TMO_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  input  logic                  pix_vld,
  input  logic                  pix_data,
  output logic                  pix_rdy,
  output logic                  res_vld,
  output logic [OUT_LEN-1:0]    res_bits,
  output logic [CLS_W-1:0]      res_class,
  output logic                  res_none,
  output logic                  res_tmo,
  input  logic                  res_ack,
  output logic                  eng_en,
  input  logic                  eng_finish,
  input  logic [X_ADDR_LEN-1:0] eng_x_addr,
  input  logic [X_SEL_LEN-1:0]  eng_x_sel,
  input  logic                  eng_x_wq,
  input  logic                  eng_wx_write,
  input  logic                  eng_out_vld,
  input  logic                  eng_out_bit,
  output logic [X_ADDR_LEN-1:0] mem_x_addr,
  output logic [X_SEL_LEN-1:0]  mem_x_sel,
  output logic                  mem_x_wq,
  output logic                  mem_x_wdata
);
  import bnn_pkg::*;

  localparam int OCW = $clog2(OUT_LEN + 1);

  sched_state_e          state, state_nxt;
  logic [X_ADDR_LEN-1:0] pix_cnt;
  logic [OCW-1:0]        out_cnt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_inc;
  logic                  tmo_hit, cap, pix_last;
  logic [OUT_LEN-1:0]    res_bits_nxt;
  logic [CLS_W-1:0]      fo_cls;
  logic                  fo_none;

  // Loader side of the X port, held stable from setup through the wq-low cycle.
  logic [X_ADDR_LEN-1:0] ld_addr;
  logic [X_SEL_LEN-1:0]  ld_sel;
  logic                  ld_data, ld_wq, loader_own;

  assign tmo_inc  = tmo_cnt + TMO_W'(1);
  assign tmo_hit  = (tmo_inc == {TMO_W{1'b1}});
  assign pix_last = (pix_cnt == X_ADDR_LEN'(X1_LEN - 1));
  assign cap      = (state == S_RUN) && eng_out_vld && (out_cnt < OCW'(OUT_LEN));

  always_comb begin
    res_bits_nxt = res_bits;
    for (int i = 0; i < OUT_LEN; i++) begin
      if (cap && (out_cnt == OCW'(i))) res_bits_nxt[i] = eng_out_bit;
    end
  end

  // Class is encoded from the bits as they will be after this cycle's capture,
  // so a strobe coinciding with the exit is reflected in the result.
  bnn_first_one #(.N(OUT_LEN), .W(CLS_W)) u_first_one (
    .bits (res_bits_nxt),
    .cls  (fo_cls),
    .none (fo_none)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LD_WAIT;
      S_LD_WAIT: if (pix_vld) state_nxt = S_LD_WR;
      S_LD_WR:   state_nxt = S_LD_FIN;
      S_LD_FIN:  state_nxt = pix_last ? S_ARM : S_LD_WAIT;
      S_ARM:     state_nxt = S_RUN;
      S_RUN: begin
        if ((cap && (out_cnt == OCW'(OUT_LEN - 1))) || eng_finish || tmo_hit)
          state_nxt = S_DONE;
      end
      S_DONE:    if (res_ack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      pix_rdy   <= 1'b0;
      eng_en    <= 1'b0;
      ld_wq     <= 1'b0;
      res_vld   <= 1'b0;
      res_bits  <= '0;
      res_class <= '0;
      res_none  <= 1'b0;
      res_tmo   <= 1'b0;
      pix_cnt   <= '0;
      out_cnt   <= '0;
      tmo_cnt   <= '0;
      ld_addr   <= '0;
      ld_sel    <= '0;
      ld_data   <= 1'b0;
    end else begin
      // Status outputs are registered from the next state so they line up with it.
      busy    <= (state_nxt != S_IDLE);
      pix_rdy <= (state_nxt == S_LD_WAIT);
      eng_en  <= (state_nxt == S_RUN);
      ld_wq   <= (state_nxt == S_LD_WR);
      res_vld <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            pix_cnt   <= '0;
            out_cnt   <= '0;
            tmo_cnt   <= '0;
            res_bits  <= '0;
            res_class <= '0;
            res_none  <= 1'b0;
            res_tmo   <= 1'b0;
          end
        end
        S_LD_WAIT: begin
          if (pix_vld) begin
            ld_data <= pix_data;
            ld_addr <= pix_cnt;
            ld_sel  <= X_SEL_LEN'(BANK_X1);
          end
        end
        S_LD_FIN: begin
          if (!pix_last) pix_cnt <= pix_cnt + X_ADDR_LEN'(1);
        end
        S_RUN: begin
          tmo_cnt  <= tmo_inc;
          res_bits <= res_bits_nxt;
          if (cap) out_cnt <= out_cnt + OCW'(1);
          if (state_nxt == S_DONE) begin
            res_class <= fo_cls;
            res_none  <= fo_none;
            res_tmo   <= tmo_hit;
          end
        end
        default: ;
      endcase
    end
  end

  // Port ownership follows the registered state: loader through LD_FIN, engine afterwards.
  assign loader_own  = (state == S_IDLE) || (state == S_LD_WAIT) ||
                       (state == S_LD_WR) || (state == S_LD_FIN);
  assign mem_x_addr  = loader_own ? ld_addr : eng_x_addr;
  assign mem_x_sel   = loader_own ? ld_sel  : eng_x_sel;
  assign mem_x_wq    = loader_own ? ld_wq   : eng_x_wq;
  assign mem_x_wdata = loader_own ? ld_data : eng_wx_write;

endmodule

// File: tb/tb_bnn_run_scheduler.sv
// tb/tb_bnn_run_scheduler.sv - directed self-checking bench for bnn_run_scheduler
module tb_bnn_run_scheduler;

  localparam int XA = 10;
  localparam int XS = 2;
  localparam int NP = 4;
  localparam int NO = 3;
  localparam int CW = 2;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst_n, start, pix_vld, pix_data, res_ack;
  logic          eng_finish, eng_x_wq, eng_wx_write, eng_out_vld, eng_out_bit;
  logic [XA-1:0] eng_x_addr;
  logic [XS-1:0] eng_x_sel;
  logic          busy, pix_rdy, res_vld, res_none, res_tmo, eng_en, mem_x_wq, mem_x_wdata;
  logic [NO-1:0] res_bits;
  logic [CW-1:0] res_class;
  logic [XA-1:0] mem_x_addr;
  logic [XS-1:0] mem_x_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bnn_run_scheduler #(
    .X_ADDR_LEN(XA), .X_SEL_LEN(XS), .X1_LEN(NP), .OUT_LEN(NO), .CLS_W(CW), .TMO_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .pix_vld(pix_vld), .pix_data(pix_data), .pix_rdy(pix_rdy),
    .res_vld(res_vld), .res_bits(res_bits), .res_class(res_class), .res_none(res_none),
    .res_tmo(res_tmo), .res_ack(res_ack), .eng_en(eng_en), .eng_finish(eng_finish),
    .eng_x_addr(eng_x_addr), .eng_x_sel(eng_x_sel), .eng_x_wq(eng_x_wq),
    .eng_wx_write(eng_wx_write), .eng_out_vld(eng_out_vld), .eng_out_bit(eng_out_bit),
    .mem_x_addr(mem_x_addr), .mem_x_sel(mem_x_sel), .mem_x_wq(mem_x_wq),
    .mem_x_wdata(mem_x_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Loads four pixels with pix_vld held high; ends one cycle into RUN.
  task automatic load_image(input logic [3:0] pix);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_rdy", {31'd0, pix_rdy}, 32'd1);
    pix_vld = 1'b1;
    for (int i = 0; i < NP; i++) begin
      pix_data = pix[i];
      tick();
      chk("wr_wq_hi", {31'd0, mem_x_wq}, 32'd1);
      chk("wr_addr", {22'd0, mem_x_addr}, i);
      chk("wr_sel", {30'd0, mem_x_sel}, 32'd0);
      chk("wr_data", {31'd0, mem_x_wdata}, {31'd0, pix[i]});
      chk("wr_rdy_lo", {31'd0, pix_rdy}, 32'd0);
      tick();
      chk("fin_wq_lo", {31'd0, mem_x_wq}, 32'd0);
      chk("fin_addr", {22'd0, mem_x_addr}, i);
      tick();
      if (i < NP - 1) begin
        chk("wait_rdy", {31'd0, pix_rdy}, 32'd1);
        chk("wait_wq", {31'd0, mem_x_wq}, 32'd0);
      end
    end
    pix_vld = 1'b0;
    chk("arm_en_lo", {31'd0, eng_en}, 32'd0);
    chk("arm_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("run_en_hi", {31'd0, eng_en}, 32'd1);
  endtask

  task automatic ack_result();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("ack_vld_lo", {31'd0, res_vld}, 32'd0);
    chk("ack_busy_lo", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, pix_rdy}, 32'd0);
    chk("rst_vld", {31'd0, res_vld}, 32'd0);
    chk("rst_en", {31'd0, eng_en}, 32'd0);
    chk("rst_wq", {31'd0, mem_x_wq}, 32'd0);
    chk("rst_bits", {29'd0, res_bits}, 32'd0);
    chk("rst_none", {31'd0, res_none}, 32'd0);
    chk("rst_tmo", {31'd0, res_tmo}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_write();
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_vld = 1'b1;
    pix_data = 1'b1;
    tick();
    chk("mid_wq_hi", {31'd0, mem_x_wq}, 32'd1);
    pix_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_wq_lo", {31'd0, mem_x_wq}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_rdy", {31'd0, pix_rdy}, 32'd0);
    chk("mid_en", {31'd0, eng_en}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    load_image(4'b1101);
    eng_x_addr = 10'h2A5;
    eng_x_sel = 2'd2;
    eng_x_wq = 1'b1;
    eng_wx_write = 1'b1;
    #1;
    chk("mux_addr", {22'd0, mem_x_addr}, 32'h2A5);
    chk("mux_sel", {30'd0, mem_x_sel}, 32'd2);
    chk("mux_wq", {31'd0, mem_x_wq}, 32'd1);
    chk("mux_wdata", {31'd0, mem_x_wdata}, 32'd1);
    eng_x_wq = 1'b0;
    eng_out_vld = 1'b1;
    eng_out_bit = 1'b0; tick();
    eng_out_bit = 1'b1; tick();
    chk("cap_not_done", {31'd0, res_vld}, 32'd0);
    eng_out_bit = 1'b1; tick();
    eng_out_vld = 1'b0;
    chk("cap_vld", {31'd0, res_vld}, 32'd1);
    chk("cap_bits", {29'd0, res_bits}, 32'b110);
    chk("cap_class", {30'd0, res_class}, 32'd1);
    chk("cap_none", {31'd0, res_none}, 32'd0);
    chk("cap_tmo", {31'd0, res_tmo}, 32'd0);
    chk("cap_en_lo", {31'd0, eng_en}, 32'd0);
    tick(); tick(); tick();
    chk("cap_vld_held", {31'd0, res_vld}, 32'd1);
    ack_result();
    chk("cap_bits_kept", {29'd0, res_bits}, 32'b110);
  endtask

  task automatic test_extra_strobe();
    load_image(4'b0010);
    eng_out_vld = 1'b1;
    eng_out_bit = 1'b0;
    tick(); tick(); tick();
    eng_out_bit = 1'b1;
    tick();
    eng_out_vld = 1'b0;
    chk("xs_vld", {31'd0, res_vld}, 32'd1);
    chk("xs_bits", {29'd0, res_bits}, 32'd0);
    chk("xs_none", {31'd0, res_none}, 32'd1);
    chk("xs_class", {30'd0, res_class}, 32'd0);
    ack_result();
  endtask

  task automatic test_timeout();
    int run_cycles;
    int budget;
    load_image(4'b0110);
    run_cycles = 1;
    budget = 0;
    while (!res_vld && budget < 200) begin
      tick();
      budget++;
      if (eng_en) run_cycles++;
    end
    chk("tmo_reached", {31'd0, res_vld}, 32'd1);
    chk("tmo_cycles", run_cycles, 32'd63);
    chk("tmo_flag", {31'd0, res_tmo}, 32'd1);
    chk("tmo_en_lo", {31'd0, eng_en}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("tmo_start_ign_vld", {31'd0, res_vld}, 32'd1);
    chk("tmo_start_ign_tmo", {31'd0, res_tmo}, 32'd1);
    chk("tmo_start_ign_rdy", {31'd0, pix_rdy}, 32'd0);
    ack_result();
  endtask

  task automatic test_finish();
    load_image(4'b1001);
    eng_out_vld = 1'b1;
    eng_out_bit = 1'b1;
    tick();
    eng_out_vld = 1'b0;
    eng_finish = 1'b1;
    tick();
    eng_finish = 1'b0;
    chk("fin_vld", {31'd0, res_vld}, 32'd1);
    chk("fin_bits", {29'd0, res_bits}, 32'b001);
    chk("fin_class", {30'd0, res_class}, 32'd0);
    chk("fin_none", {31'd0, res_none}, 32'd0);
    chk("fin_tmo", {31'd0, res_tmo}, 32'd0);
    ack_result();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_vld = 1'b0; pix_data = 1'b0; res_ack = 1'b0;
    eng_finish = 1'b0; eng_x_addr = '0; eng_x_sel = '0; eng_x_wq = 1'b0;
    eng_wx_write = 1'b0; eng_out_vld = 1'b0; eng_out_bit = 1'b0;
    test_reset();
    test_reset_mid_write();
    test_capture();
    test_extra_strobe();
    test_timeout();
    test_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
